// File: rtl/stream_checker_pkg.sv
// Shared types and default expected stream for stream_checker.
// STREAM_CHECKER_TIMEOUT_EN enables the idle-timeout feature in the top.
package stream_checker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_DEF = 42;

   localparam logic [8*N_DEF-1:0] EXP_DEF =
      336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753;

   // Byte 0 is the most-significant byte of the vector.
   function automatic logic [7:0] exp_byte(
      input logic [8*N_DEF-1:0] vec,
      input int                 idx
   );
      return vec[8*(N_DEF-1-idx) +: 8];
   endfunction

endpackage

// File: rtl/stream_checker_if.sv
// Byte stream link from the transform block into the checker.
// No backpressure: the consumer accepts every valid byte.
interface stream_checker_if;

   logic [7:0] data;
   logic       valid;

   modport master (
      output data,
      output valid
   );

   modport slave (
      input data,
      input valid
   );

endinterface

// File: rtl/stream_exp_sel.sv
// Combinational expected-byte mux, indexed by the accepted-byte count.
// Kept as its own block so it can later become a ROM lookup.
module stream_exp_sel
   import stream_checker_pkg::*;
#(
   parameter int             N   = N_DEF,
   parameter logic [8*N-1:0] EXP = EXP_DEF,
   parameter int             CW  = $clog2(N+1)
) (
   input  logic [CW-1:0] idx,
   output logic [7:0]    exp_b
);

   always_comb begin
      exp_b = '0;
      for (int i = 0; i < N; i++) begin
         if (idx == CW'(i)) exp_b = EXP[8*(N-1-i) +: 8];
      end
   end

endmodule

// File: rtl/stream_checker.sv
// On-the-fly byte stream checker: compares N bytes against EXP.
// Define STREAM_CHECKER_TIMEOUT_EN for the idle timeout and timeout port.
module stream_checker
   import stream_checker_pkg::*;
#(
   parameter int             N       = N_DEF,
   parameter logic [8*N-1:0] EXP     = EXP_DEF,
`ifdef STREAM_CHECKER_TIMEOUT_EN
   parameter int             TIMEOUT = 64,
`endif
   parameter int             CW      = $clog2(N+1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   stream_checker_if.slave        s,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [CW-1:0]          mismatch_cnt,
   output logic [CW-1:0]          first_err_idx,
   output logic [CW-1:0]          byte_cnt,
`ifdef STREAM_CHECKER_TIMEOUT_EN
   output logic                   timeout,
`endif
   output logic                   overflow
);

   localparam logic [CW-1:0] NC   = CW'(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] mm, mm_n;
   logic [CW-1:0] fe, fe_n;
   logic          pass_q, pass_n;
   logic          ovf, ovf_n;
   logic [7:0]    exp_b;

`ifdef STREAM_CHECKER_TIMEOUT_EN
   localparam int            TW   = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
   logic [TW-1:0] idle, idle_n;
   logic          tmo, tmo_n;
`endif

   stream_exp_sel #(
      .N   (N),
      .EXP (EXP),
      .CW  (CW)
   ) u_sel (
      .idx   (cnt),
      .exp_b (exp_b)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      mm_n    = mm;
      fe_n    = fe;
      pass_n  = pass_q;
      ovf_n   = ovf;
`ifdef STREAM_CHECKER_TIMEOUT_EN
      idle_n  = idle;
      tmo_n   = tmo;
`endif
      // start wins over a same-cycle byte in every state
      if (start) begin
         state_n = RUN;
         cnt_n   = '0;
         mm_n    = '0;
         fe_n    = NC;
         pass_n  = 1'b0;
         ovf_n   = 1'b0;
`ifdef STREAM_CHECKER_TIMEOUT_EN
         idle_n  = '0;
         tmo_n   = 1'b0;
`endif
      end else begin
         unique case (state)
            RUN: begin
               if (s.valid) begin
                  cnt_n = cnt + 1'b1;
                  if (exp_b != s.data) begin
                     if (mm != NC) mm_n = mm + 1'b1;
                     if (fe == NC) fe_n = cnt;
                  end
                  if (cnt == LAST) begin
                     state_n = DONE;
                     pass_n  = (mm_n == '0);
                  end
`ifdef STREAM_CHECKER_TIMEOUT_EN
                  idle_n = '0;
               end else if (idle == TLIM) begin
                  state_n = DONE;
                  pass_n  = 1'b0;
                  tmo_n   = 1'b1;
               end else begin
                  idle_n = idle + 1'b1;
`endif
               end
            end
            DONE: begin
               if (s.valid) begin
                  ovf_n  = 1'b1;
                  pass_n = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         mm     <= '0;
         fe     <= NC;
         pass_q <= 1'b0;
         ovf    <= 1'b0;
`ifdef STREAM_CHECKER_TIMEOUT_EN
         idle   <= '0;
         tmo    <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mm     <= mm_n;
         fe     <= fe_n;
         pass_q <= pass_n;
         ovf    <= ovf_n;
`ifdef STREAM_CHECKER_TIMEOUT_EN
         idle   <= idle_n;
         tmo    <= tmo_n;
`endif
      end
   end

   assign busy          = (state == RUN);
   assign done          = (state == DONE);
   assign pass          = pass_q & done;
   assign mismatch_cnt  = mm;
   assign first_err_idx = fe;
   assign byte_cnt      = cnt;
   assign overflow      = ovf;
`ifdef STREAM_CHECKER_TIMEOUT_EN
   assign timeout       = tmo;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker: expected run results are queued
// as streams are driven and popped when the checker reports done.
module tb_stream_checker;

   localparam int N = 42;
   localparam logic [8*N-1:0] REF =
      336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753;

   typedef struct {
      logic p;
      int   mm;
      int   fe;
      int   cnt;
      logic ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, pass, overflow;
   logic [5:0] mismatch_cnt, first_err_idx, byte_cnt;
`ifdef STREAM_CHECKER_TIMEOUT_EN
   logic       timeout;
`endif

   logic [8*N-1:0] refv;
   exp_t           q[$];
   int             total = 0;
   int             bad = 0;

   stream_checker_if sif ();

   stream_checker dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .s             (sif.slave),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .mismatch_cnt  (mismatch_cnt),
      .first_err_idx (first_err_idx),
      .byte_cnt      (byte_cnt),
`ifdef STREAM_CHECKER_TIMEOUT_EN
      .timeout       (timeout),
`endif
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] refb(input int i);
      return refv[8*(N-1-i) +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      sif.valid = v;
      sif.data  = d;
      tick();
      sif.valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Drives bytes [0,nb) with indices c0/c1 corrupted; full streams queue a result.
   task automatic send_stream(input int c0, input int c1,
                              input int gap, input int nb);
      exp_t e;
      logic [7:0] b;
      e.mm = 0;
      e.fe = N;
      for (int i = 0; i < nb; i++) begin
         repeat ($urandom_range(0, gap)) tick();
         b = refb(i);
         if (i == c0 || i == c1) b = b ^ 8'h01;
         if (b != refb(i)) begin
            e.mm++;
            if (e.fe == N) e.fe = i;
         end
         drive(1'b1, b);
      end
      if (nb == N) begin
         e.p   = (e.mm == 0);
         e.cnt = N;
         e.ov  = 1'b0;
         q.push_back(e);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total += 7;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset.busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL reset.done got=%b exp=0", done); end
      if (pass !== 1'b0) begin bad++; $display("FAIL reset.pass got=%b exp=0", pass); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL reset.ovf got=%b exp=0", overflow); end
      if (mismatch_cnt !== 6'd0) begin bad++; $display("FAIL reset.mm got=%0d exp=0", mismatch_cnt); end
      if (first_err_idx !== 6'd42) begin bad++; $display("FAIL reset.fe got=%0d exp=42", first_err_idx); end
      if (byte_cnt !== 6'd0) begin bad++; $display("FAIL reset.cnt got=%0d exp=0", byte_cnt); end
      drive(1'b1, 8'h30);
      total += 2;
      if (byte_cnt !== 6'd0) begin bad++; $display("FAIL idle_ignore.cnt got=%0d exp=0", byte_cnt); end
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_ignore.busy got=%b exp=0", busy); end
   endtask

   task automatic test_start_drop();
      start = 1'b1;
      drive(1'b1, 8'h30);
      start = 1'b0;
      total += 2;
      if (busy !== 1'b1) begin bad++; $display("FAIL start_drop.busy got=%b exp=1", busy); end
      if (byte_cnt !== 6'd0) begin bad++; $display("FAIL start_drop.cnt got=%0d exp=0", byte_cnt); end
      do_reset();
   endtask

   task automatic test_exact();
      exp_t e;
      pulse_start();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL exact.busy got=%b exp=1", busy); end
      send_stream(-1, -1, 0, N - 1);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL exact.early_done got=%b exp=0", done); end
      drive(1'b1, refb(N - 1));
      e = '{p: 1'b1, mm: 0, fe: N, cnt: N, ov: 1'b0};
      total += 6;
      if (done !== 1'b1) begin bad++; $display("FAIL exact.done got=%b exp=1", done); end
      if (busy !== 1'b0) begin bad++; $display("FAIL exact.busy_end got=%b exp=0", busy); end
      if (pass !== e.p) begin bad++; $display("FAIL exact.pass got=%b exp=%b", pass, e.p); end
      if (mismatch_cnt !== 6'(e.mm)) begin bad++; $display("FAIL exact.mm got=%0d exp=%0d", mismatch_cnt, e.mm); end
      if (first_err_idx !== 6'(e.fe)) begin bad++; $display("FAIL exact.fe got=%0d exp=%0d", first_err_idx, e.fe); end
      if (byte_cnt !== 6'(e.cnt)) begin bad++; $display("FAIL exact.cnt got=%0d exp=%0d", byte_cnt, e.cnt); end
   endtask

   task automatic test_corrupt();
      exp_t e;
      pulse_start();
      send_stream(5, 20, 3, N);
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL corrupt.queue got=0 exp=1");
      end else begin
         e = q.pop_front();
         total += 5;
         if (done !== 1'b1) begin bad++; $display("FAIL corrupt.done got=%b exp=1", done); end
         if (pass !== e.p) begin bad++; $display("FAIL corrupt.pass got=%b exp=%b", pass, e.p); end
         if (mismatch_cnt !== 6'(e.mm)) begin bad++; $display("FAIL corrupt.mm got=%0d exp=%0d", mismatch_cnt, e.mm); end
         if (first_err_idx !== 6'(e.fe)) begin bad++; $display("FAIL corrupt.fe got=%0d exp=%0d", first_err_idx, e.fe); end
         if (byte_cnt !== 6'(e.cnt)) begin bad++; $display("FAIL corrupt.cnt got=%0d exp=%0d", byte_cnt, e.cnt); end
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      pulse_start();
      send_stream(-1, -1, 1, N);
      drive(1'b1, 8'h00);
      tick();
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL ovf.queue got=0 exp=1");
      end else begin
         e = q.pop_front();
         e.p  = 1'b0;
         e.ov = 1'b1;
         total += 5;
         if (done !== 1'b1) begin bad++; $display("FAIL ovf.done got=%b exp=1", done); end
         if (overflow !== e.ov) begin bad++; $display("FAIL ovf.flag got=%b exp=%b", overflow, e.ov); end
         if (pass !== e.p) begin bad++; $display("FAIL ovf.pass got=%b exp=%b", pass, e.p); end
         if (byte_cnt !== 6'(e.cnt)) begin bad++; $display("FAIL ovf.cnt got=%0d exp=%0d", byte_cnt, e.cnt); end
         if (mismatch_cnt !== 6'(e.mm)) begin bad++; $display("FAIL ovf.mm got=%0d exp=%0d", mismatch_cnt, e.mm); end
      end
   endtask

   task automatic test_rst_mid();
      exp_t e;
      pulse_start();
      send_stream(2, -1, 0, 10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total += 4;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid.busy got=%b exp=0", busy); end
      if (byte_cnt !== 6'd0) begin bad++; $display("FAIL rst_mid.cnt got=%0d exp=0", byte_cnt); end
      if (mismatch_cnt !== 6'd0) begin bad++; $display("FAIL rst_mid.mm got=%0d exp=0", mismatch_cnt); end
      if (first_err_idx !== 6'd42) begin bad++; $display("FAIL rst_mid.fe got=%0d exp=42", first_err_idx); end
      pulse_start();
      send_stream(-1, -1, 0, N);
      e = q.pop_front();
      total += 3;
      if (pass !== e.p) begin bad++; $display("FAIL rst_mid.pass got=%b exp=%b", pass, e.p); end
      if (mismatch_cnt !== 6'(e.mm)) begin bad++; $display("FAIL rst_mid.mm2 got=%0d exp=%0d", mismatch_cnt, e.mm); end
      if (first_err_idx !== 6'(e.fe)) begin bad++; $display("FAIL rst_mid.fe2 got=%0d exp=%0d", first_err_idx, e.fe); end
   endtask

   task automatic test_restart();
      exp_t e;
      pulse_start();
      send_stream(3, 17, 0, 30);
      start = 1'b1;
      drive(1'b1, 8'hff);
      start = 1'b0;
      total += 4;
      if (busy !== 1'b1) begin bad++; $display("FAIL restart.busy got=%b exp=1", busy); end
      if (byte_cnt !== 6'd0) begin bad++; $display("FAIL restart.cnt got=%0d exp=0", byte_cnt); end
      if (mismatch_cnt !== 6'd0) begin bad++; $display("FAIL restart.mm got=%0d exp=0", mismatch_cnt); end
      if (first_err_idx !== 6'd42) begin bad++; $display("FAIL restart.fe got=%0d exp=42", first_err_idx); end
      send_stream(-1, -1, 2, N);
      e = q.pop_front();
      total += 4;
      if (done !== 1'b1) begin bad++; $display("FAIL restart.done got=%b exp=1", done); end
      if (pass !== e.p) begin bad++; $display("FAIL restart.pass got=%b exp=%b", pass, e.p); end
      if (mismatch_cnt !== 6'(e.mm)) begin bad++; $display("FAIL restart.mm2 got=%0d exp=%0d", mismatch_cnt, e.mm); end
      if (byte_cnt !== 6'(e.cnt)) begin bad++; $display("FAIL restart.cnt2 got=%0d exp=%0d", byte_cnt, e.cnt); end
   endtask

`ifdef STREAM_CHECKER_TIMEOUT_EN
   task automatic test_timeout();
      int k;
      do_reset();
      pulse_start();
      send_stream(-1, -1, 0, 3);
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      total += 5;
      if (k != 64) begin bad++; $display("FAIL timeout.cycles got=%0d exp=64", k); end
      if (timeout !== 1'b1) begin bad++; $display("FAIL timeout.flag got=%b exp=1", timeout); end
      if (done !== 1'b1) begin bad++; $display("FAIL timeout.done got=%b exp=1", done); end
      if (pass !== 1'b0) begin bad++; $display("FAIL timeout.pass got=%b exp=0", pass); end
      if (byte_cnt !== 6'd3) begin bad++; $display("FAIL timeout.cnt got=%0d exp=3", byte_cnt); end
   endtask
`endif

   initial begin
      refv      = REF;
      sif.valid = 1'b0;
      sif.data  = 8'h00;
      test_reset();
      test_start_drop();
      test_exact();
      test_corrupt();
      test_overflow();
      test_rst_mid();
      test_restart();
`ifdef STREAM_CHECKER_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_checker.md
Name: stream_checker

Overview:
- Downstream consumer of the byte-stream transform block (clk, data_out[7:0], valid_out).
- Captures N output bytes in order and compares each, on the fly, against a parameterised expected vector.
- Reports done, pass, mismatch count and first failing index.
- Replaces the testbench-level whole-vector compare with a synthesizable, re-armable checker.

Parameters:
- N, 42, number of bytes per stream.
- EXP, 8*N-bit, default 'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753; expected stream, byte 0 = most-significant byte.
- CW, $clog2(N+1), width of the counters.
- TIMEOUT, 64, idle-cycle limit (used only with the optional feature).

Ports:
- clk  in  1  single clock, posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  arm pulse; clears results and enters RUN.
- data_in  in  8  byte from the upstream data_out.
- valid_in  in  1  byte qualifier from the upstream valid_out. No backpressure: always accepted in RUN.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid only while done is high.
- mismatch_cnt  out  CW  number of bytes that differed.
- first_err_idx  out  CW  index of the first differing byte; N if none.
- byte_cnt  out  CW  bytes accepted this run.
- overflow  out  1  a byte arrived after N bytes were accepted.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - All outputs 0, except first_err_idx=N.
- FSM IDLE→RUN→DONE.
  - IDLE: valid_in ignored. start → RUN, clearing counters, first_err_idx=N, overflow=0.
  - RUN: on valid_in, compare data_in with EXP[8*(N-1-byte_cnt) +: 8].
    - On mismatch, mismatch_cnt++. If first_err_idx==N, first_err_idx=byte_cnt.
    - byte_cnt++ every accepted byte.
    - When the accepted byte is index N-1 → DONE. done and pass are registered and visible the cycle after that byte's posedge.
    - pass = (final mismatch_cnt==0).
  - DONE: valid_in → overflow=1 and pass=0 (sticky); no counters change. start → RUN with a full clear.
- start while in RUN restarts the run: counters cleared, the same-cycle valid_in byte is dropped.
- start and valid_in in the same IDLE cycle: the byte is dropped.
- mismatch_cnt saturates at N (cannot exceed it by construction).
- rst mid-run returns to the reset state immediately.
- N=1: a single byte moves the FSM straight to DONE.
- Expected-byte select is combinational from byte_cnt; no pipeline stage in the compare path.

Optional Feature:
- Macro: STREAM_CHECKER_TIMEOUT_EN.
- Defined:
  - A CW-independent idle counter runs in RUN and resets on each valid_in.
  - Reaching TIMEOUT consecutive idle cycles forces DONE with pass=0.
  - Adds output timeout (1 bit, sticky until start/rst).
- Undefined: no counter, no timeout port; RUN waits indefinitely.

Decomposition:
- Package stream_checker_pkg holds:
  - State enum {IDLE, RUN, DONE} (2 bits).
  - Default EXP and N constants.
  - Function exp_byte(vec, idx).
- One sub-module, stream_exp_sel: combinational 8*N→8 byte mux indexed by byte_cnt. Kept separate so it can later be swapped for a ROM.

Test Plan:
- Exact match: start, then 42 bytes 0x30,0x78,0x9d,…,0x53 with valid every cycle → done 1 cycle after the last byte; pass=1, mismatch_cnt=0, first_err_idx=42, byte_cnt=42.
- Corrupt bytes 5 and 20 (XOR 0x01), valid with random gaps → pass=0, mismatch_cnt=2, first_err_idx=5.
- Matching stream plus one extra valid byte 0x00 in DONE → overflow=1, pass=0, byte_cnt stays 42.
- rst after 10 bytes, then start and a full matching stream → pass=1; no residue from the first run.
- start re-asserted at byte 30 of a corrupt stream, then a clean 42-byte stream → pass=1, mismatch_cnt=0.
- Timeout (macro defined, TIMEOUT=64): start, 3 bytes, then silence → timeout=1, done=1 exactly 64 idle cycles after the last byte; pass=0.
